// File: rtl/iob_pkg.sv
// Shared definitions for the CPU-side I/O bus slave port: FSM states,
// bus widths and the request record held in the posted-write buffer.
package iob_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACT,
        FIN
    } iob_state_e;

    // One I/O cycle as seen by the master: direction, byte lanes, address, data.
    typedef struct packed {
        logic              rnw;
        logic              lds;
        logic              uds;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } iob_req_t;

    // Idle bus: read direction, no lanes, zero address/data.
    localparam iob_req_t REQ_RESET = '{rnw: 1'b1, lds: 1'b0, uds: 1'b0, addr: '0, data: '0};

endpackage

// File: rtl/iob_sync.sv
// N-flop level synchroniser bringing a master-domain handshake signal
// into the FCLK domain; cleared by the synchronous reset.
module iob_sync #(
    parameter int N = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    // Fewer than two stages would not resolve metastability.
    localparam int STAGES = (N < 2) ? 2 : N;

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour.
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/iob_slave_post.sv
// CPU-side I/O bus slave port. Buffers one I/O cycle, drives the PDS
// master's request interface and retires the cycle on the synchronised
// IOACT/IODONE handshake, with optional write posting and a watchdog.
module iob_slave_post
    import iob_pkg::*;
#(
    parameter bit POST_WR     = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic              FCLK,
    input  logic              RES,
    input  logic              CPU_REQ,
    input  logic              CPU_RnW,
    input  logic              CPU_LDS,
    input  logic              CPU_UDS,
    input  logic [ADDR_W-1:0] CPU_A,
    input  logic [DATA_W-1:0] CPU_D,
    output logic              CPU_ACK,
    output logic              CPU_BERR,
    output logic              IOREQ,
    output logic              IORW,
    output logic              IOLDS,
    output logic              IOUDS,
    output logic [ADDR_W-1:0] IOA,
    output logic [DATA_W-1:0] IOD,
    input  logic              IOACT,
    input  logic              IODONE,
    output logic              IOBUSY
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    iob_state_e state_q, state_d;
    iob_req_t   cur_q, cur_d;       // cycle currently presented to the master
    iob_req_t   pend_q, pend_d;     // one-deep latch for a request arriving while busy
    logic       pend_v_q, pend_v_d;
    logic       ioreq_q, ioreq_d;
    logic       iobusy_q, iobusy_d;
    logic       ack_q, ack_d;
    logic       berr_q, berr_d;
    logic       posted_q, posted_d; // current cycle already acknowledged to the CPU
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       acts, dones;
    iob_req_t   cpu_in;
    iob_req_t   launch_req;
    logic       launch;
    logic       fin;
    logic       fin_err;
    logic       timeout_hit;

    iob_sync #(.N(SYNC_STAGES)) u_sync_act (
        .clk_i (FCLK),
        .rst_i (RES),
        .d_i   (IOACT),
        .q_o   (acts)
    );

    iob_sync #(.N(SYNC_STAGES)) u_sync_done (
        .clk_i (FCLK),
        .rst_i (RES),
        .d_i   (IODONE),
        .q_o   (dones)
    );

    assign cpu_in      = '{rnw: CPU_RnW, lds: CPU_LDS, uds: CPU_UDS, addr: CPU_A, data: CPU_D};
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state, request buffering and handshake decode.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        ioreq_d    = ioreq_q;
        iobusy_d   = iobusy_q;
        ack_d      = 1'b0;
        berr_d     = 1'b0;
        posted_d   = posted_q;
        cnt_d      = '0;
        launch     = 1'b0;
        launch_req = cpu_in;
        fin        = 1'b0;
        fin_err    = 1'b0;

        // Any CPU request is parked first; IDLE may consume it straight away.
        if (CPU_REQ) begin
            pend_v_d = 1'b1;
            pend_d   = cpu_in;
        end

        unique case (state_q)
            IDLE: begin
                // A new IOREQ only goes out once ACTs is seen low, so a late
                // ACT from an aborted cycle can never be mistaken for a grant.
                if (!acts) begin
                    if (pend_v_q) begin
                        launch     = 1'b1;
                        launch_req = pend_q;
                        pend_v_d   = CPU_REQ;
                    end else if (CPU_REQ) begin
                        launch     = 1'b1;
                        launch_req = cpu_in;
                        pend_v_d   = 1'b0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (acts) begin
                    ioreq_d = 1'b0;
                    state_d = ACT;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    ioreq_d = 1'b0;
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            ACT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!acts) begin
                    fin     = 1'b1;
                    fin_err = !dones;
                end else if (timeout_hit) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (launch) begin
            cur_d    = launch_req;
            ioreq_d  = 1'b1;
            iobusy_d = 1'b1;
            posted_d = POST_WR && !launch_req.rnw;
            ack_d    = POST_WR && !launch_req.rnw;
            state_d  = REQ;
        end

        // Entering FIN: terminate unposted cycles; posted-write errors are dropped.
        if (fin) begin
            state_d  = FIN;
            iobusy_d = 1'b0;
            cnt_d    = '0;
            ack_d    = !posted_q;
            berr_d   = !posted_q && fin_err;
        end
    end

    // State and output registers; reset returns the bus to idle with no acknowledge.
    always_ff @(posedge FCLK) begin
        if (RES) begin
            state_q  <= IDLE;
            cur_q    <= REQ_RESET;
            pend_q   <= REQ_RESET;
            pend_v_q <= 1'b0;
            ioreq_q  <= 1'b0;
            iobusy_q <= 1'b0;
            ack_q    <= 1'b0;
            berr_q   <= 1'b0;
            posted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ioreq_q  <= ioreq_d;
            iobusy_q <= iobusy_d;
            ack_q    <= ack_d;
            berr_q   <= berr_d;
            posted_q <= posted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign CPU_ACK  = ack_q;
    assign CPU_BERR = berr_q;
    assign IOREQ    = ioreq_q;
    assign IORW     = cur_q.rnw;
    assign IOLDS    = cur_q.lds;
    assign IOUDS    = cur_q.uds;
    assign IOA      = cur_q.addr;
    assign IOD      = cur_q.data;
    assign IOBUSY   = iobusy_q;

endmodule
